flop_toggle_sequencer: RTL and testbench

- Controller that drives the clear/set/toggle command inputs of one external flip_flop instance to produce a programmable-duty square wave.
- The high and low phase lengths are counted in clock-enabled cycles.
- Provides glitch-free start and stop.
- Checks the flip-flop's state feedback and forces it low with a sticky fault on mismatch.

---
 rtl/flop_toggle_sequencer_pkg.sv | 14 +
 rtl/flop_toggle_sequencer_phase_down_counter.sv | 38 +++
 rtl/flop_toggle_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_flop_toggle_sequencer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/flop_toggle_sequencer_pkg.sv
// Shared types and constants for the flip-flop toggle sequencer.
//   seq_state_e   : sequencer FSM states (idle, driving high, driving low)
//   SEQ_MIN_PHASE : shortest legal phase length; a requested 0 is raised to this
package flop_toggle_sequencer_pkg;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_HIGH = 2'd1,
    SEQ_LOW  = 2'd2
  } seq_state_e;

  localparam int SEQ_MIN_PHASE = 1;

endpackage

// File: rtl/flop_toggle_sequencer_phase_down_counter.sv
// Phase-length down-counter for the toggle sequencer.
// Ports:
//   clk, async_rst : clock and asynchronous active-high reset (count -> 0)
//   clk_en         : clock enable; the count is frozen while low
//   load_i         : load load_val_i (wins over the decrement)
//   load_val_i     : value to load
//   count_o        : current count
//   zero_o         : count is zero (terminal count of the current phase)
module phase_down_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             async_rst,
  input  logic             clk_en,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic [CNT_W-1:0] count_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      count_q <= '0;
    end else if (clk_en) begin
      if (load_i) begin
        count_q <= load_val_i;
      end else if (count_q != '0) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/flop_toggle_sequencer.sv
// Drives the clear/set/toggle commands of one external flip-flop to produce a
// square wave with programmable high and low phase lengths (in enabled cycles).
// Start and stop are glitch-free: a stop request lets the current phase finish
// and the wave always ends low. The flip-flop's state is checked at each phase
// end; a mismatch clears it and raises a sticky fault until the next start.
//
// Optional build macro FLOP_TOGGLE_SEQUENCER_LIVE_RELOAD_EN: when defined, the
// phase lengths are re-sampled from the inputs at every toggle boundary;
// otherwise they are captured only at start.
//
// Ports:
//   clk, async_rst      : clock, asynchronous active-high reset
//   clk_en              : clock enable; state frozen and commands held off when low
//   start_i, stop_i     : start (IDLE only) / graceful stop request
//   high_cycles_i       : high-phase length, 0 treated as 1
//   low_cycles_i        : low-phase length, 0 treated as 1
//   state_i             : flip-flop state feedback
//   clear_en_o, set_en_o, toggle_en_o : flip-flop commands (at most one high)
//   busy_o              : sequencer not idle
//   fault_o             : sticky feedback-mismatch flag
module flop_toggle_sequencer
  import flop_toggle_sequencer_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             async_rst,
  input  logic             clk_en,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic [CNT_W-1:0] high_cycles_i,
  input  logic [CNT_W-1:0] low_cycles_i,
  input  logic             state_i,
  output logic             clear_en_o,
  output logic             set_en_o,
  output logic             toggle_en_o,
  output logic             busy_o,
  output logic             fault_o
);

  function automatic logic [CNT_W-1:0] min_phase(input logic [CNT_W-1:0] v);
    return (v < CNT_W'(SEQ_MIN_PHASE)) ? CNT_W'(SEQ_MIN_PHASE) : v;
  endfunction

  seq_state_e       state_q, state_d;
  logic             stop_pend_q, stop_pend_d;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [CNT_W-1:0] hi_rl, lo_rl;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_zero;
  logic             stop_req;
  logic             set_c, clr_c, tog_c;

  phase_down_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk        (clk),
    .async_rst  (async_rst),
    .clk_en     (clk_en),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .count_o    (cnt_val),
    .zero_o     (cnt_zero)
  );

  // Phase lengths to use for the phase entered at a toggle boundary.
`ifdef FLOP_TOGGLE_SEQUENCER_LIVE_RELOAD_EN
  assign hi_rl = min_phase(high_cycles_i);
  assign lo_rl = min_phase(low_cycles_i);
`else
  assign hi_rl = hi_q;
  assign lo_rl = lo_q;
`endif

  // A stop arriving in the terminal cycle of a phase counts as already pending.
  assign stop_req = stop_pend_q | stop_i;

  always_comb begin
    state_d      = state_q;
    stop_pend_d  = stop_pend_q;
    fault_d      = fault_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    set_c        = 1'b0;
    clr_c        = 1'b0;
    tog_c        = 1'b0;
    if (clk_en) begin
      case (state_q)
        SEQ_IDLE: begin
          if (start_i && !stop_i) begin
            set_c        = 1'b1;
            hi_d         = min_phase(high_cycles_i);
            lo_d         = min_phase(low_cycles_i);
            cnt_load     = 1'b1;
            cnt_load_val = min_phase(high_cycles_i) - CNT_W'(1);
            fault_d      = 1'b0;
            stop_pend_d  = 1'b0;
            state_d      = SEQ_HIGH;
          end
        end
        SEQ_HIGH: begin
          if (stop_i) stop_pend_d = 1'b1;
          if (cnt_zero) begin
            if (!state_i) begin
              clr_c       = 1'b1;
              fault_d     = 1'b1;
              stop_pend_d = 1'b0;
              state_d     = SEQ_IDLE;
            end else begin
              tog_c        = 1'b1;
              hi_d         = hi_rl;
              lo_d         = lo_rl;
              cnt_load     = 1'b1;
              cnt_load_val = lo_rl - CNT_W'(1);
              if (stop_req) begin
                stop_pend_d = 1'b0;
                state_d     = SEQ_IDLE;
              end else begin
                state_d     = SEQ_LOW;
              end
            end
          end
        end
        SEQ_LOW: begin
          if (stop_i) stop_pend_d = 1'b1;
          if (cnt_zero) begin
            if (state_i) begin
              clr_c       = 1'b1;
              fault_d     = 1'b1;
              stop_pend_d = 1'b0;
              state_d     = SEQ_IDLE;
            end else if (stop_req) begin
              // Output already low: stop without issuing a command.
              stop_pend_d = 1'b0;
              state_d     = SEQ_IDLE;
            end else begin
              tog_c        = 1'b1;
              hi_d         = hi_rl;
              lo_d         = lo_rl;
              cnt_load     = 1'b1;
              cnt_load_val = hi_rl - CNT_W'(1);
              state_d      = SEQ_HIGH;
            end
          end
        end
        default: state_d = SEQ_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      state_q     <= SEQ_IDLE;
      stop_pend_q <= 1'b0;
      fault_q     <= 1'b0;
    end else if (clk_en) begin
      state_q     <= state_d;
      stop_pend_q <= stop_pend_d;
      fault_q     <= fault_d;
    end
  end

  // Phase lengths are data: only meaningful after a start, so no reset.
  always_ff @(posedge clk) begin
    if (clk_en) begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign set_en_o    = set_c;
  assign clear_en_o  = clr_c;
  assign toggle_en_o = tog_c;
  assign busy_o      = (state_q != SEQ_IDLE);
  assign fault_o     = fault_q;

endmodule

// File: tb/tb_flop_toggle_sequencer.sv
module tb_flop_toggle_sequencer;

  localparam int CNT_W = 16;

  logic             clk;
  logic             rst;
  logic             clk_en;
  logic             start_i;
  logic             stop_i;
  logic [CNT_W-1:0] high_cycles;
  logic [CNT_W-1:0] low_cycles;
  logic             force_lo;
  logic             ff_q;
  logic             state_fb;
  logic             clear_en, set_en, toggle_en, busy, fault;

  typedef struct {
    logic [5:0] v;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  flop_toggle_sequencer #(.CNT_W(CNT_W)) dut (
    .clk           (clk),
    .async_rst     (rst),
    .clk_en        (clk_en),
    .start_i       (start_i),
    .stop_i        (stop_i),
    .high_cycles_i (high_cycles),
    .low_cycles_i  (low_cycles),
    .state_i       (state_fb),
    .clear_en_o    (clear_en),
    .set_en_o      (set_en),
    .toggle_en_o   (toggle_en),
    .busy_o        (busy),
    .fault_o       (fault)
  );

  // External flip-flop being sequenced (clear > set > toggle, clock-enabled).
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              ff_q <= 1'b0;
    else if (clk_en) begin
      if (clear_en)       ff_q <= 1'b0;
      else if (set_en)    ff_q <= 1'b1;
      else if (toggle_en) ff_q <= ~ff_q;
    end
  end

  assign state_fb = force_lo ? 1'b0 : ff_q;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  // Observed tuple: {set, clear, toggle, busy, fault, state_i}
  function automatic logic [5:0] observed();
    return {set_en, clear_en, toggle_en, busy, fault, state_fb};
  endfunction

  // One clock cycle: drive inputs, queue the expected outputs, compare at negedge.
  task automatic cyc(input logic st, input logic sp, input logic en, input logic frc,
                     input logic [5:0] e, input string tag);
    exp_t ex;
    exp_t got;
    logic [5:0] obs;
    start_i  = st;
    stop_i   = sp;
    clk_en   = en;
    force_lo = frc;
    ex.v   = e;
    ex.tag = tag;
    exp_q.push_back(ex);
    @(negedge clk);
    obs = observed();
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL %s scoreboard empty obs=%b", tag, obs);
    end else begin
      got = exp_q.pop_front();
      assert (obs === got.v) else begin
        bad++;
        $error("FAIL %s obs=%b exp=%b", got.tag, obs, got.v);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_now(input logic [5:0] e, input string tag);
    logic [5:0] obs;
    obs = observed();
    total++;
    assert (obs === e) else begin
      bad++;
      $error("FAIL %s obs=%b exp=%b", tag, obs, e);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic s1_period();
    cyc(0, 0, 1, 0, 6'b000101, "s1_h1");
    cyc(0, 0, 1, 0, 6'b000101, "s1_h2");
    cyc(0, 0, 1, 0, 6'b001101, "s1_h_tog");
    cyc(0, 0, 1, 0, 6'b000100, "s1_l1");
    cyc(0, 0, 1, 0, 6'b001100, "s1_l_tog");
  endtask

  initial begin
    rst = 1'b1; clk_en = 1'b1; start_i = 1'b0; stop_i = 1'b0; force_lo = 1'b0;
    high_cycles = '0; low_cycles = '0;
    @(posedge clk); @(posedge clk); #1;
    chk_now(6'b000000, "reset_state");
    rst = 1'b0;

    // hi=3, lo=2 running wave
    high_cycles = 16'd3; low_cycles = 16'd2;
    cyc(1, 0, 1, 0, 6'b100000, "s1_set");
    s1_period();
    s1_period();
    cyc(0, 0, 1, 0, 6'b000101, "s1_h1_pre_rst");

    // asynchronous reset in the middle of a high phase
    rst = 1'b1;
    #1;
    chk_now(6'b000000, "rst_mid_high");
    @(posedge clk); #1;
    rst = 1'b0;
    cyc(0, 0, 1, 0, 6'b000000, "post_rst_idle");
    cyc(1, 0, 1, 0, 6'b100000, "s1b_set");
    s1_period();
    do_reset();

    // zero lengths behave as 1/1; clock-enable gating; start while busy
    high_cycles = 16'd0; low_cycles = 16'd0;
    cyc(1, 0, 1, 0, 6'b100000, "s2_set");
    cyc(0, 0, 1, 0, 6'b001101, "s2_tog_h");
    cyc(0, 0, 0, 0, 6'b000100, "s2_gated");
    cyc(0, 0, 1, 0, 6'b001100, "s2_tog_l");
    cyc(1, 0, 1, 0, 6'b001101, "s2_start_busy");
    cyc(0, 0, 1, 0, 6'b001100, "s2_tog_l2");
    do_reset();

    // start together with stop is ignored
    high_cycles = 16'd4; low_cycles = 16'd4;
    cyc(1, 1, 1, 0, 6'b000000, "s3_start_stop");
    // stop early in high: phase completes, ends low, then silent
    cyc(1, 0, 1, 0, 6'b100000, "s3_set");
    cyc(0, 1, 1, 0, 6'b000101, "s3_h1_stop");
    cyc(0, 1, 1, 0, 6'b000101, "s3_h2_stop");
    cyc(0, 0, 1, 0, 6'b000101, "s3_h3");
    cyc(0, 0, 1, 0, 6'b001101, "s3_final_tog");
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 6'b000000, "s3_idle");

    // clock enable held low in the middle of a low phase (lo=3)
    high_cycles = 16'd2; low_cycles = 16'd3;
    cyc(1, 0, 1, 0, 6'b100000, "s4_set");
    cyc(0, 0, 1, 0, 6'b000101, "s4_h1");
    cyc(0, 0, 1, 0, 6'b001101, "s4_h_tog");
    cyc(0, 0, 1, 0, 6'b000100, "s4_l1");
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 6'b000100, "s4_frozen");
    cyc(0, 0, 1, 0, 6'b000100, "s4_l2");
    cyc(0, 0, 1, 0, 6'b001100, "s4_l_tog");
    cyc(0, 0, 1, 0, 6'b000101, "s4_h1b");
    cyc(0, 0, 1, 0, 6'b001101, "s4_h_togb");
    cyc(0, 0, 1, 0, 6'b000100, "s4_l1b");
    cyc(0, 0, 1, 0, 6'b000100, "s4_l2b");
    cyc(0, 0, 1, 0, 6'b001100, "s4_l_togb");
    cyc(0, 0, 1, 0, 6'b000101, "s5_h1");

    // feedback forced low at high terminal count -> clear and sticky fault
    cyc(0, 0, 1, 1, 6'b010100, "s5_clr");
    cyc(0, 0, 1, 0, 6'b000010, "s5_fault_idle1");
    cyc(0, 0, 1, 0, 6'b000010, "s5_fault_idle2");
    high_cycles = 16'd1; low_cycles = 16'd1;
    cyc(1, 0, 1, 0, 6'b100010, "s5_restart");
    cyc(0, 0, 1, 0, 6'b001101, "s5_fault_cleared");
    cyc(0, 0, 1, 0, 6'b001100, "s5_tog_l");
    cyc(0, 0, 1, 1, 6'b010100, "s5_clr2");
    cyc(0, 0, 1, 0, 6'b000010, "s5_fault2");

    // reset clears the fault immediately
    rst = 1'b1;
    #1;
    chk_now(6'b000000, "rst_clears_fault");
    @(posedge clk); #1;
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
